// File: rtl/incdec_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : incdec_sched_pkg
//  Description : Shared types for the scheduled increment/decrement counter
//                bank. Defines the operation encoding that requesters drive
//                on req_op.
//  Revision    : 1.0  initial release
// ============================================================================
package incdec_sched_pkg;

   // Encoding matches the 2-bit req_op field.
   typedef enum logic [1:0] {
      OP_READ = 2'b00,
      OP_INC  = 2'b01,
      OP_DEC  = 2'b10,
      OP_CLR  = 2'b11
   } op_e;

endpackage : incdec_sched_pkg
`default_nettype wire

// File: rtl/incdec_counter_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter. Grants the first valid
//                requester at or after ptr, searching upward modulo NREQ.
//  Ports       : valid     - request vector
//                ptr       - round-robin start position (0..NREQ-1)
//                enable    - when low, no grant is issued
//                grant     - one-hot grant (or zero)
//                grant_idx - index of the granted requester
//                grant_any - a grant was issued
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
   parameter  int NREQ = 4,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] valid,
   input  logic [IDW-1:0]  ptr,
   input  logic            enable,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  grant_idx,
   output logic            grant_any
);

   localparam logic [IDW:0] c_NREQ = (IDW+1)'(NREQ);

   // One extra bit so ptr + k can be wrapped back into 0..NREQ-1 even when
   // NREQ is not a power of two.
   logic [IDW:0] w_pos;
   logic         w_found;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      w_found   = 1'b0;
      w_pos     = '0;
      for (int k = 0; k < NREQ; k++) begin
         w_pos = {1'b0, ptr} + (IDW+1)'(k);
         if (w_pos >= c_NREQ) begin
            w_pos = w_pos - c_NREQ;
         end
         if (enable && !w_found && valid[w_pos[IDW-1:0]]) begin
            w_found                 = 1'b1;
            grant[w_pos[IDW-1:0]]   = 1'b1;
            grant_idx               = w_pos[IDW-1:0];
         end
      end
      grant_any = w_found;
   end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/incdec_counter_sched.sv
`default_nettype none
// ============================================================================
//  Module      : incdec_counter_sched
//  Description : Shared counter bank with a single read-modify-write port.
//                NREQ requesters issue READ / INC / DEC / CLR on indexed
//                counters; one request per cycle is chosen round-robin and
//                the pre-operation value is returned (a++ / a-- semantics).
//  Ports       : clk, rst_n         - clock, async active-low reset
//                req_valid/ready    - per-requester handshake (ready one-hot)
//                req_idx, req_op    - packed per-requester index and op
//                rsp_valid/ready    - response handshake
//                rsp_id, rsp_data   - granted requester, old counter value
//                rsp_wrap           - INC from all-ones or DEC from zero
//  Revision    : 1.0  initial release
// ============================================================================
module incdec_counter_sched
   import incdec_sched_pkg::*;
#(
   parameter  int NREQ  = 4,
   parameter  int NCNT  = 8,
   parameter  int WIDTH = 32,
   localparam int IDXW  = $clog2(NCNT),
   localparam int IDW   = $clog2(NREQ)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NREQ-1:0]    req_valid,
   output logic [NREQ-1:0]    req_ready,
   input  logic [NREQ*IDXW-1:0] req_idx,
   input  logic [NREQ*2-1:0]  req_op,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [IDW-1:0]     rsp_id,
   output logic [WIDTH-1:0]   rsp_data,
   output logic               rsp_wrap
);

   // Field widths follow the instance parameters, so the response record
   // is declared here rather than in the shared package.
   typedef struct packed {
      logic [IDW-1:0]   id;
      logic [WIDTH-1:0] data;
      logic             wrap;
   } rsp_t;

   localparam logic [IDW-1:0] c_LAST = IDW'(NREQ - 1);

   logic [WIDTH-1:0] r_cnt [NCNT];
   logic [IDW-1:0]   r_ptr;
   logic             r_rsp_valid;
   rsp_t             r_rsp;

   logic             w_enable;
   logic [NREQ-1:0]  w_grant;
   logic [IDW-1:0]   w_gidx;
   logic             w_any;
   logic [IDXW-1:0]  w_sel_idx;
   op_e              w_sel_op;
   logic [WIDTH-1:0] w_old;
   logic [WIDTH-1:0] w_new;
   logic             w_wrap;
   logic             w_write;
   logic [IDW-1:0]   w_ptr_next;

   // A new grant may only be issued when the output register is free or is
   // being drained this cycle. Reset also suppresses grants so req_ready
   // reads zero while rst_n is low.
   assign w_enable = rst_n && (!r_rsp_valid || rsp_ready);

   rr_arbiter #(
      .NREQ (NREQ)
   ) u_arb (
      .valid     (req_valid),
      .ptr       (r_ptr),
      .enable    (w_enable),
      .grant     (w_grant),
      .grant_idx (w_gidx),
      .grant_any (w_any)
   );

   assign req_ready = w_grant;

   // Pick the index/op of the granted requester.
   always_comb begin
      w_sel_idx = '0;
      w_sel_op  = OP_READ;
      for (int r = 0; r < NREQ; r++) begin
         if (w_gidx == IDW'(r)) begin
            w_sel_idx = req_idx[r*IDXW +: IDXW];
            w_sel_op  = op_e'(req_op[r*2 +: 2]);
         end
      end
   end

   // The single shared adder/subtractor.
   always_comb begin
      w_old   = r_cnt[w_sel_idx];
      w_new   = w_old;
      w_wrap  = 1'b0;
      w_write = 1'b0;
      case (w_sel_op)
         OP_INC: begin
            w_new   = w_old + WIDTH'(1);
            w_wrap  = &w_old;
            w_write = 1'b1;
         end
         OP_DEC: begin
            w_new   = w_old - WIDTH'(1);
            w_wrap  = ~|w_old;
            w_write = 1'b1;
         end
         OP_CLR: begin
            w_new   = '0;
            w_write = 1'b1;
         end
         default: begin
            w_new   = w_old;
         end
      endcase
   end

   assign w_ptr_next = (w_gidx == c_LAST) ? '0 : w_gidx + 1'b1;

   // Counter storage is flops, so a write at edge N is seen by a read in
   // cycle N+1 without any forwarding.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NCNT; i++) begin
            r_cnt[i] <= '0;
         end
      end else if (w_any && w_write) begin
         r_cnt[w_sel_idx] <= w_new;
      end
   end

   // Response register and round-robin pointer. A grant reloads the
   // register (covers accept-and-grant in the same cycle); an accept with
   // no grant empties it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr       <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp       <= '0;
      end else if (w_any) begin
         r_ptr       <= w_ptr_next;
         r_rsp_valid <= 1'b1;
         r_rsp       <= '{id: w_gidx, data: w_old, wrap: w_wrap};
      end else if (rsp_ready) begin
         r_rsp_valid <= 1'b0;
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_id    = r_rsp.id;
   assign rsp_data  = r_rsp.data;
   assign rsp_wrap  = r_rsp.wrap;

endmodule : incdec_counter_sched
`default_nettype wire

// File: tb/tb_incdec_counter_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_incdec_counter_sched
//  Description : Self-checking bench for incdec_counter_sched. A behavioural
//                counter model predicts each response when its grant is seen
//                and queues it; responses are popped and compared on accept.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_incdec_counter_sched;

   localparam int NREQ = 4;
   localparam int NCNT = 8;
   localparam int WIDTH = 32;
   localparam int IDXW = 3;
   localparam int IDW = 2;

   typedef struct packed {
      logic [IDW-1:0]   id;
      logic [WIDTH-1:0] data;
      logic             wrap;
   } exp_t;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*IDXW-1:0] req_idx;
   logic [NREQ*2-1:0]    req_op;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [IDW-1:0]       rsp_id;
   logic [WIDTH-1:0]     rsp_data;
   logic                 rsp_wrap;

   int          n_cmp = 0;
   int          n_bad = 0;
   exp_t        q[$];
   logic [WIDTH-1:0] m_cnt [NCNT];
   int          m_ptr;

   incdec_counter_sched #(
      .NREQ (NREQ),
      .NCNT (NCNT),
      .WIDTH(WIDTH)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_idx  (req_idx),
      .req_op   (req_op),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_id   (rsp_id),
      .rsp_data (rsp_data),
      .rsp_wrap (rsp_wrap)
   );

   always #5 clk = ~clk;

   task automatic model_clear();
      for (int i = 0; i < NCNT; i++) m_cnt[i] = '0;
      m_ptr = 0;
      q.delete();
   endtask

   task automatic set_req(input int r, input int idx, input int op);
      req_valid[r]              = 1'b1;
      req_idx[r*IDXW +: IDXW]   = IDXW'(idx);
      req_op[r*2 +: 2]          = 2'(op);
   endtask

   // One cycle: sample outputs #1 after the negedge setup, predict any
   // granted op into the queue, then advance to the next negedge.
   task automatic tick(output logic acc, output logic vld, output exp_t obs,
                       output logic [NREQ-1:0] gnt);
      logic [IDXW-1:0] idx;
      logic [1:0]      op;
      logic [WIDTH-1:0] old;
      exp_t            e;
      #1;
      gnt = req_ready;
      vld = rsp_valid;
      acc = rsp_valid && rsp_ready;
      obs = {rsp_id, rsp_data, rsp_wrap};
      for (int r = 0; r < NREQ; r++) begin
         if (req_valid[r] && req_ready[r]) begin
            idx    = req_idx[r*IDXW +: IDXW];
            op     = req_op[r*2 +: 2];
            old    = m_cnt[idx];
            e.id   = IDW'(r);
            e.data = old;
            e.wrap = (op == 2'd1 && old == 32'hFFFF_FFFF) || (op == 2'd2 && old == 32'd0);
            case (op)
               2'd1: m_cnt[idx] = old + 32'd1;
               2'd2: m_cnt[idx] = old - 32'd1;
               2'd3: m_cnt[idx] = 32'd0;
               default: ;
            endcase
            q.push_back(e);
            m_ptr = (r + 1) % NREQ;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_drain(input string name);
      logic acc, vld;
      exp_t obs, e;
      logic [NREQ-1:0] gnt;
      req_valid = '0;
      rsp_ready = 1'b1;
      for (int k = 0; k < 20 && q.size() > 0; k++) begin
         tick(acc, vld, obs, gnt);
         if (acc) begin
            e = q.pop_front();
            n_cmp++;
            if (obs !== e) begin
               n_bad++;
               $display("FAIL %s_drain rsp: got id=%0d data=%h wrap=%b, want id=%0d data=%h wrap=%b",
                        name, obs.id, obs.data, obs.wrap, e.id, e.data, e.wrap);
            end
         end
      end
      n_cmp++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL %s_timeout: %0d responses outstanding, want 0", name, q.size());
      end
   endtask

   // Runs a single-requester op sequence back-to-back with rsp_ready=1.
   task automatic run_seq(input string name, input int r, input int idxs[$], input int ops[$]);
      logic acc, vld;
      exp_t obs, e;
      logic [NREQ-1:0] gnt;
      rsp_ready = 1'b1;
      for (int k = 0; k < ops.size(); k++) begin
         set_req(r, idxs[k], ops[k]);
         tick(acc, vld, obs, gnt);
         n_cmp++;
         if (gnt !== NREQ'(1 << r)) begin
            n_bad++;
            $display("FAIL %s_grant step %0d: got %b, want %b", name, k, gnt, NREQ'(1 << r));
         end
         if (acc) begin
            e = q.pop_front();
            n_cmp++;
            if (obs !== e) begin
               n_bad++;
               $display("FAIL %s rsp: got id=%0d data=%h wrap=%b, want id=%0d data=%h wrap=%b",
                        name, obs.id, obs.data, obs.wrap, e.id, e.data, e.wrap);
            end
         end
      end
      test_drain(name);
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      req_valid = '1;
      rsp_ready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      n_cmp += 5;
      if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b, want 0", rsp_valid); end
      if (rsp_id !== '0)      begin n_bad++; $display("FAIL reset_rsp_id: got %0d, want 0", rsp_id); end
      if (rsp_data !== '0)    begin n_bad++; $display("FAIL reset_rsp_data: got %h, want 0", rsp_data); end
      if (rsp_wrap !== 1'b0)  begin n_bad++; $display("FAIL reset_rsp_wrap: got %b, want 0", rsp_wrap); end
      if (req_ready !== '0)   begin n_bad++; $display("FAIL reset_req_ready: got %b, want 0000", req_ready); end
      req_valid = '0;
      rst_n     = 1'b1;
      model_clear();
      @(negedge clk);
   endtask

   task automatic test_inc_seq();
      run_seq("inc_seq", 0, '{2, 2, 2}, '{1, 1, 1});
   endtask

   task automatic test_round_robin();
      logic acc, vld;
      exp_t obs, e;
      logic [NREQ-1:0] gnt, want;
      rsp_ready = 1'b1;
      for (int r = 0; r < NREQ; r++) set_req(r, 0, 0);
      for (int k = 0; k < 8; k++) begin
         want = NREQ'(1 << m_ptr);
         tick(acc, vld, obs, gnt);
         n_cmp++;
         if (gnt !== want) begin
            n_bad++;
            $display("FAIL rr_grant cycle %0d: got %b, want %b", k, gnt, want);
         end
         if (acc) begin
            e = q.pop_front();
            n_cmp++;
            if (obs !== e) begin
               n_bad++;
               $display("FAIL rr rsp: got id=%0d data=%h wrap=%b, want id=%0d data=%h wrap=%b",
                        obs.id, obs.data, obs.wrap, e.id, e.data, e.wrap);
            end
         end
      end
      test_drain("rr");
   endtask

   task automatic test_wrap();
      // DEC from 0, READ, INC from all-ones, READ
      run_seq("wrap", 1, '{5, 5, 5, 5}, '{2, 0, 1, 0});
   endtask

   task automatic test_stall();
      logic acc, vld;
      exp_t obs, e, held;
      logic [NREQ-1:0] gnt;
      rsp_ready = 1'b1;
      set_req(0, 4, 1);
      tick(acc, vld, obs, gnt);
      rsp_ready = 1'b0;
      set_req(2, 4, 1);
      held = '0;
      for (int k = 0; k < 3; k++) begin
         tick(acc, vld, obs, gnt);
         if (k == 0) held = obs;
         n_cmp += 2;
         if (gnt !== '0) begin n_bad++; $display("FAIL stall_grant cycle %0d: got %b, want 0000", k, gnt); end
         if (vld !== 1'b1) begin n_bad++; $display("FAIL stall_valid cycle %0d: got %b, want 1", k, vld); end
         if (k > 0) begin
            n_cmp++;
            if (obs !== held) begin
               n_bad++;
               $display("FAIL stall_hold cycle %0d: got data=%h, want data=%h", k, obs.data, held.data);
            end
         end
      end
      rsp_ready = 1'b1;
      tick(acc, vld, obs, gnt);
      n_cmp++;
      if (gnt === '0) begin n_bad++; $display("FAIL stall_resume: got grant %b, want nonzero", gnt); end
      if (acc) begin
         e = q.pop_front();
         n_cmp++;
         if (obs !== e) begin
            n_bad++;
            $display("FAIL stall rsp: got id=%0d data=%h wrap=%b, want id=%0d data=%h wrap=%b",
                     obs.id, obs.data, obs.wrap, e.id, e.data, e.wrap);
         end
      end
      test_drain("stall");
   endtask

   task automatic test_clr();
      run_seq("clr", 3, '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1},
                        '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 3, 0});
   endtask

   task automatic test_back_to_back();
      // Counter 3 brought to 5, then two INCs return 5 and 6; READ sees 7.
      run_seq("b2b", 2, '{3, 3, 3, 3, 3, 3, 3, 3, 3},
                        '{3, 1, 1, 1, 1, 1, 1, 1, 0});
   endtask

   task automatic test_reset_mid();
      logic acc, vld;
      exp_t obs;
      logic [NREQ-1:0] gnt;
      rsp_ready = 1'b0;
      set_req(0, 2, 1);
      tick(acc, vld, obs, gnt);
      req_valid = '0;
      #2 rst_n = 1'b0;
      #1;
      n_cmp += 2;
      if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid: got %b, want 0", rsp_valid); end
      if (req_ready !== '0)   begin n_bad++; $display("FAIL rstmid_ready: got %b, want 0000", req_ready); end
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
      run_seq("rstmid", 0, '{0, 1, 2, 3, 4, 5, 6, 7}, '{0, 0, 0, 0, 0, 0, 0, 0});
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      req_idx   = '0;
      req_op    = '0;
      rsp_ready = 1'b0;
      model_clear();
      test_reset();
      test_inc_seq();
      test_round_robin();
      test_wrap();
      test_stall();
      test_clr();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_incdec_counter_sched
`default_nettype wire
